// File: rtl/risc_core_mc.sv
`default_nettype none
// ============================================================================
// Module   : risc_core_mc
// Purpose  : Parametrised multi-cycle RISC core. Control FSM, 8-entry
//            register file, ALU, PC and IR in one block, sharing a single
//            handshaked memory port (mem_req/mem_ready) for instruction and
//            data accesses. Status byte = {err, halted, C, N, Z, state}.
// Options  : `define MEM_TIMEOUT_EN adds a mem_ready wait watchdog that halts
//            the core with err=1 after TIMEOUT stalled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module risc_core_mc #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] D_in,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] D_out,
  output logic [ADDR_W-1:0] Address,
  output logic              mem_req,
  output logic              mw_en,
  output logic [7:0]        status,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] c_OP_ADD  = 4'h1;
  localparam logic [3:0] c_OP_SUB  = 4'h2;
  localparam logic [3:0] c_OP_AND  = 4'h3;
  localparam logic [3:0] c_OP_OR   = 4'h4;
  localparam logic [3:0] c_OP_XOR  = 4'h5;
  localparam logic [3:0] c_OP_NOT  = 4'h6;
  localparam logic [3:0] c_OP_SHL  = 4'h7;
  localparam logic [3:0] c_OP_SHR  = 4'h8;
  localparam logic [3:0] c_OP_LDI  = 4'h9;
  localparam logic [3:0] c_OP_LD   = 4'hA;
  localparam logic [3:0] c_OP_ST   = 4'hB;
  localparam logic [3:0] c_OP_JMP  = 4'hC;
  localparam logic [3:0] c_OP_JZ   = 4'hD;
  localparam logic [3:0] c_OP_JN   = 4'hE;
  localparam logic [3:0] c_OP_HALT = 4'hF;

  // Elaboration-time parameter sanity checks
  if (DATA_W < 16) begin : g_bad_data_w
    $error("risc_core_mc: DATA_W must be >= 16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("risc_core_mc: TIMEOUT must be >= 1");
  end

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_regs [0:7];
  logic [DATA_W-1:0] r_a, r_b, r_dv;
  logic              r_z, r_n, r_c;
  logic              r_mem_req, r_mw_en, r_halted;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dout;

  logic [3:0]        w_op;
  logic [2:0]        w_rd, w_rs, w_rt;
  logic [7:0]        w_imm8;
  logic [DATA_W-1:0] w_b_op;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_res;
  logic              w_cout;
  logic              w_alu_op, w_wr_rd;
  logic [ADDR_W-1:0] w_a_addr;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_jump;
  logic [ADDR_W-1:0] w_exec_pc;
  logic              w_timeout;
  logic              w_err;

  assign w_op   = r_ir[15:12];
  assign w_rd   = r_ir[11:9];
  assign w_rs   = r_ir[8:6];
  assign w_rt   = r_ir[5:3];
  assign w_imm8 = r_ir[7:0];

  // SUB reuses the adder as A + ~B + 1 so carry-out means "no borrow"
  assign w_b_op = (w_op == c_OP_SUB) ? ~r_b : r_b;
  assign w_sum  = {1'b0, r_a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, (w_op == c_OP_SUB)};

  // Register values are truncated or zero-extended to the address width
  assign w_a_addr = ADDR_W'(r_a);
  assign w_pc_inc = r_pc + ADDR_W'(1);

  assign w_jump    = (w_op == c_OP_JMP) ||
                     ((w_op == c_OP_JZ) && r_z) ||
                     ((w_op == c_OP_JN) && r_n);
  assign w_exec_pc = w_jump ? w_a_addr : r_pc;

  assign w_alu_op = (w_op >= c_OP_ADD) && (w_op <= c_OP_SHR);
  assign w_wr_rd  = w_alu_op || (w_op == c_OP_LDI);

  // ALU result and carry for the current opcode (operands latched in DECODE)
  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    case (w_op)
      c_OP_ADD, c_OP_SUB: begin
        w_res  = w_sum[DATA_W-1:0];
        w_cout = w_sum[DATA_W];
      end
      c_OP_AND: w_res = r_a & r_b;
      c_OP_OR:  w_res = r_a | r_b;
      c_OP_XOR: w_res = r_a ^ r_b;
      c_OP_NOT: w_res = ~r_a;
      c_OP_SHL: begin
        w_res  = {r_a[DATA_W-2:0], 1'b0};
        w_cout = r_a[DATA_W-1];
      end
      c_OP_SHR: begin
        w_res  = {1'b0, r_a[DATA_W-1:1]};
        w_cout = r_a[0];
      end
      c_OP_LDI: w_res = {{(DATA_W-8){w_imm8[7]}}, w_imm8};
      default:  w_res = '0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int c_TCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [c_TCNT_W-1:0] r_tcnt;
  logic                r_err;

  assign w_timeout = r_mem_req && !mem_ready && (r_tcnt >= c_TCNT_W'(TIMEOUT - 1));
  assign w_err     = r_err;

  // Stall counter: runs while a request waits, restarts with every new access
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_mem_req && !mem_ready && !w_timeout)
        r_tcnt <= r_tcnt + c_TCNT_W'(1);
      else
        r_tcnt <= '0;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_err     = 1'b0;
`endif

  // Control FSM with registered bus outputs; all architectural state lives here
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_dv      <= '0;
      r_z       <= 1'b0;
      r_n       <= 1'b0;
      r_c       <= 1'b0;
      r_mem_req <= 1'b0;
      r_mw_en   <= 1'b0;
      r_halted  <= 1'b0;
      r_addr    <= '0;
      r_dout    <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (r_mem_req && mem_ready) begin
            r_ir      <= D_in[15:0];
            r_pc      <= w_pc_inc;
            r_state   <= S_DECODE;
            r_mem_req <= 1'b0;
            r_addr    <= '0;
          end else if (w_timeout) begin
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
            r_mem_req <= 1'b0;
            r_addr    <= '0;
          end else begin
            // First cycle out of reset the request is still low; raise it here
            r_mem_req <= 1'b1;
            r_addr    <= r_pc;
          end
        end

        S_DECODE: begin
          r_a     <= r_regs[w_rs];
          r_b     <= r_regs[w_rt];
          r_dv    <= r_regs[w_rd];
          r_state <= S_EXEC;
        end

        S_EXEC: begin
          if (w_wr_rd)
            r_regs[w_rd] <= w_res;
          if (w_alu_op) begin
            r_z <= (w_res == '0);
            r_n <= w_res[DATA_W-1];
            r_c <= w_cout;
          end
          if ((w_op == c_OP_LD) || (w_op == c_OP_ST)) begin
            r_state   <= S_MEM;
            r_mem_req <= 1'b1;
            r_addr    <= w_a_addr;
            r_mw_en   <= (w_op == c_OP_ST);
            r_dout    <= (w_op == c_OP_ST) ? r_dv : '0;
          end else if (w_op == c_OP_HALT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_pc      <= w_exec_pc;
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
            r_addr    <= w_exec_pc;
          end
        end

        S_MEM: begin
          if (mem_ready) begin
            if (!r_mw_en)
              r_regs[w_rd] <= D_in;
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
            r_addr    <= r_pc;
            r_mw_en   <= 1'b0;
            r_dout    <= '0;
          end else if (w_timeout) begin
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
            r_mem_req <= 1'b0;
            r_addr    <= '0;
            r_mw_en   <= 1'b0;
            r_dout    <= '0;
          end
        end

        S_HALT: begin
          r_state   <= S_HALT;
          r_halted  <= 1'b1;
          r_mem_req <= 1'b0;
          r_mw_en   <= 1'b0;
        end

        default: begin
          r_state   <= S_HALT;
          r_halted  <= 1'b1;
          r_mem_req <= 1'b0;
          r_mw_en   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req = r_mem_req;
  assign mw_en   = r_mw_en;
  assign Address = r_addr;
  assign D_out   = r_dout;
  assign halted  = r_halted;
  assign status  = {w_err, r_halted, r_c, r_n, r_z, 3'(r_state)};

endmodule
`default_nettype wire

// File: tb/tb_risc_core_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_core_mc
// Purpose  : Directed self-checking bench for risc_core_mc (default build).
//            A small program in a 256-word memory model exercises reset,
//            ALU flags, sign extension, wait-stated store/load, branches,
//            HALT and reset in the middle of a memory access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc_core_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] D_in;
  logic        mem_ready;
  logic [15:0] D_out;
  logic [15:0] Address;
  logic        mem_req;
  logic        mw_en;
  logic [7:0]  status;
  logic        halted;

  logic [15:0] mem [0:255];
  logic [15:0] img [0:255];
  logic        load_req = 1'b0;
  int          wait_n = 0;
  int          wcnt = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  risc_core_mc #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .RESET_PC(16'h0010),
    .TIMEOUT (255)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .D_in     (D_in),
    .mem_ready(mem_ready),
    .D_out    (D_out),
    .Address  (Address),
    .mem_req  (mem_req),
    .mw_en    (mw_en),
    .status   (status),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, ready after wait_n stalled cycles
  assign D_in      = mem[Address[7:0]];
  assign mem_ready = mem_req && (wcnt >= wait_n);

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (reset && mem_req && mw_en && mem_ready) begin
      mem[Address[7:0]] <= D_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Wait (bounded) for the fetch request of a given instruction address
  task automatic wait_fetch(input logic [15:0] a, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_req && status[2:0] == 3'd0 && Address == a) found = 1'b1;
    end
    check({tag, "_reached"}, {31'd0, found}, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    int mcnt;
    bit seen;

    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
    img[8'h01] = 16'hDEAD;
    img[8'h10] = 16'h927F; // LDI r1,0x7F
    img[8'h11] = 16'h9401; // LDI r2,0x01
    img[8'h12] = 16'h1650; // ADD r3,r1,r2
    img[8'h13] = 16'hB640; // ST  r3,[r1]
    img[8'h14] = 16'h9805; // LDI r4,0x05
    img[8'h15] = 16'h2B20; // SUB r5,r4,r4
    img[8'h16] = 16'h9C80; // LDI r6,0x80
    img[8'h17] = 16'hBD00; // ST  r6,[r4]
    img[8'h18] = 16'hBA80; // ST  r5,[r2]
    img[8'h19] = 16'h9440; // LDI r2,0x40
    img[8'h1A] = 16'hB280; // ST  r1,[r2]
    img[8'h1B] = 16'hAE80; // LD  r7,[r2]
    img[8'h1C] = 16'hBEC0; // ST  r7,[r3]
    img[8'h1D] = 16'h9C30; // LDI r6,0x30
    img[8'h1E] = 16'hD180; // JZ  r6
    img[8'h30] = 16'h1A50; // ADD r5,r1,r2
    img[8'h31] = 16'hD180; // JZ  r6
    img[8'h32] = 16'h9280; // LDI r1,0x80
    img[8'h33] = 16'h7640; // SHL r3,r1
    img[8'h34] = 16'h86C0; // SHR r3,r3
    img[8'h35] = 16'hB700; // ST  r3,[r4]
    img[8'h36] = 16'hF000; // HALT

    // Reset held for two edges
    reset    = 1'b0;
    load_req = 1'b1;
    repeat (2) @(negedge clk);
    load_req = 1'b0;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mw_en",   {31'd0, mw_en},   32'd0);
    check("rst_dout",    {16'd0, D_out},   32'h0);
    check("rst_halted",  {31'd0, halted},  32'd0);
    check("rst_status",  {24'd0, status},  32'h00);
    reset = 1'b1;
    @(negedge clk);
    check("fetch_req",  {31'd0, mem_req}, 32'd1);
    check("fetch_addr", {16'd0, Address}, 32'h0010);

    // ADD retires three cycles after its fetch request; 0x0080 leaves bit 15 clear
    wait_fetch(16'h0012, "add");
    t0 = cyc;
    wait_fetch(16'h0013, "add_next");
    check("add_latency", cyc - t0, 32'd3);
    check("add_flags", {24'd0, status}, 32'h00);
    wait_fetch(16'h0014, "st1");
    check("add_result", {16'd0, mem[8'h7F]}, 32'h0080);
    wait_fetch(16'h0016, "sub");
    check("sub_flags", {24'd0, status}, 32'h28);
    wait_fetch(16'h0017, "ldi");
    check("ldi_flags_kept", {24'd0, status}, 32'h28);
    wait_fetch(16'h0018, "st2");
    check("ldi_sext", {16'd0, mem[8'h05]}, 32'hFF80);
    wait_fetch(16'h0019, "st3");
    check("sub_result", {16'd0, mem[8'h01]}, 32'h0000);

    // Store with three wait states: request/strobe held for four cycles
    wait_fetch(16'h001A, "st4");
    repeat (2) @(negedge clk);
    wait_n = 3;
    mcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (status[2:0] != 3'd3) break;
      mcnt++;
      check("st_mw_en", {31'd0, mw_en},   32'd1);
      check("st_addr",  {16'd0, Address}, 32'h0040);
      check("st_dout",  {16'd0, D_out},   32'h007F);
    end
    check("st_wait_cycles", mcnt, 32'd4);
    wait_n = 0;
    wait_fetch(16'h001D, "ld");
    check("st_delayed_data", {16'd0, mem[8'h40]}, 32'h007F);
    check("ld_roundtrip",    {16'd0, mem[8'h80]}, 32'h007F);

    // Branches
    wait_fetch(16'h001E, "jz1");
    repeat (3) @(negedge clk);
    check("jz_taken_state", {29'd0, status[2:0]}, 32'd0);
    check("jz_taken", {16'd0, Address}, 32'h0030);
    wait_fetch(16'h0031, "jz2");
    check("add2_flags", {24'd0, status}, 32'h00);
    repeat (3) @(negedge clk);
    check("jz_not_taken", {16'd0, Address}, 32'h0032);

    // Shifts and HALT
    wait_fetch(16'h0034, "shl");
    check("shl_flags", {24'd0, status}, 32'h30);
    wait_fetch(16'h0035, "shr");
    check("shr_flags", {24'd0, status}, 32'h00);
    wait_fetch(16'h0036, "halt");
    check("shr_result", {16'd0, mem[8'h05]}, 32'h7F80);
    repeat (3) @(negedge clk);
    check("halt_status", {24'd0, status}, 32'h44);
    check("halt_flag",   {31'd0, halted}, 32'd1);
    repeat (5) @(negedge clk);
    check("halt_no_req", {31'd0, mem_req}, 32'd0);
    check("halt_sticky", {24'd0, status},  32'h44);

    // Reset in the middle of a stalled store: no write, restart at RESET_PC
    img[8'h7F] = 16'h1234;
    reset      = 1'b0;
    load_req   = 1'b1;
    repeat (2) @(negedge clk);
    load_req = 1'b0;
    check("reset_clears_halt", {31'd0, halted}, 32'd0);
    reset = 1'b1;
    wait_fetch(16'h0013, "st_again");
    @(negedge clk);
    wait_n = 1000;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (status[2:0] == 3'd3) seen = 1'b1;
    end
    check("mid_mem_reached", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clk);
    check("mid_mem_wen", {31'd0, mw_en}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_wen", {31'd0, mw_en},   32'd0);
    wait_n = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("restart_req", {31'd0, mem_req}, 32'd1);
    check("restart_pc",  {16'd0, Address}, 32'h0010);
    check("mid_mem_nowrite", {16'd0, mem[8'h7F]}, 32'h1234);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
